escalonador_display: RTL and testbench

- Sequences the multiplexed 4-digit seven-segment display used for machine error messages.
- Arbitrates round-robin between up to four simultaneous error flags and holds each active message on screen for a fixed number of scan frames, with a blank gap between messages.
- Each cycle it drives the 2-bit letter-select pair (saida1Contador, saida2Contador) into the error-message decoders, plus the active-low digit enables.
- Sits between the error-flag sources and the combinational message decoders.

---
 rtl/escalonador_display_if.sv | 21 ++
 rtl/escalonador_display.sv | 169 ++++++++++++++++
 tb/tb_escalonador_display.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/escalonador_display_if.sv
// Bus between the error-flag sources / message decoders and the display scheduler.
interface escalonador_display_if;
    logic       habilita;
    logic [3:0] erros;
    logic [1:0] sel_msg;
    logic       saida1Contador;
    logic       saida2Contador;
    logic [3:0] digito;
    logic       exibindo;
    logic       fim_msg;

    modport master (
        output habilita, erros,
        input  sel_msg, saida1Contador, saida2Contador, digito, exibindo, fim_msg
    );

    modport slave (
        input  habilita, erros,
        output sel_msg, saida1Contador, saida2Contador, digito, exibindo, fim_msg
    );
endinterface

// File: rtl/escalonador_display.sv
// Round-robin scheduler for the 4-digit error-message display: holds each
// message for TEMPO_MSG scan frames, then blanks for one frame before the next.
module escalonador_display #(
    parameter int DIV_VARREDURA = 50000,
    parameter int TEMPO_MSG     = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    escalonador_display_if.slave  bus
);
    localparam int PRESC_W = $clog2(DIV_VARREDURA);
    localparam int FRAME_W = (TEMPO_MSG > 1) ? $clog2(TEMPO_MSG) : 1;
    localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(DIV_VARREDURA - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(TEMPO_MSG - 1);

    typedef enum logic [1:0] {OCIOSO = 2'd0, EXIBE = 2'd1, PAUSA = 2'd2} estado_t;

    estado_t              state_r, state_nxt_s;
    logic [PRESC_W-1:0]   presc_r, presc_nxt_s;
    logic [1:0]           scan_r, scan_nxt_s;
    logic [FRAME_W-1:0]   frame_r, frame_nxt_s;
    logic [1:0]           sel_r, sel_nxt_s;
    logic                 fim_nxt_s;
    logic [3:0]           digito_r;
    logic                 exibindo_r;
    logic                 fim_r;
    logic                 tick_s;
    logic                 frame_end_s;

    function automatic logic [1:0] lowest_set(input logic [3:0] req);
        logic [1:0] res;
        res = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                res = 2'(k);
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    // Searches cur+1, cur+2, ... modulo 4; the current index itself is tried last.
    function automatic logic [1:0] next_set(input logic [3:0] req, input logic [1:0] cur);
        logic [1:0] res;
        logic [1:0] idx;
        logic       found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = cur + 2'(k);
            if (!found && req[idx]) begin
                res   = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return res;
    endfunction

    function automatic logic [3:0] digit_mask(input logic [1:0] scan);
        case (scan)
            2'd0:    return 4'b1110;
            2'd1:    return 4'b1101;
            2'd2:    return 4'b1011;
            2'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

    assign tick_s      = (presc_r == PRESC_MAX);
    assign frame_end_s = tick_s && (scan_r == 2'd3);

    // Next-state and counter logic; habilita=0 overrides every other event.
    always_comb begin
        state_nxt_s = state_r;
        presc_nxt_s = tick_s ? {PRESC_W{1'b0}} : presc_r + PRESC_W'(1);
        scan_nxt_s  = tick_s ? scan_r + 2'd1 : scan_r;
        frame_nxt_s = frame_r;
        sel_nxt_s   = sel_r;
        fim_nxt_s   = 1'b0;
        if (!bus.habilita) begin
            state_nxt_s = OCIOSO;
            presc_nxt_s = {PRESC_W{1'b0}};
            scan_nxt_s  = 2'd0;
            frame_nxt_s = {FRAME_W{1'b0}};
        end else begin
            case (state_r)
                OCIOSO: begin
                    presc_nxt_s = {PRESC_W{1'b0}};
                    scan_nxt_s  = 2'd0;
                    frame_nxt_s = {FRAME_W{1'b0}};
                    if (bus.erros != 4'b0000) begin
                        state_nxt_s = EXIBE;
                        sel_nxt_s   = lowest_set(bus.erros);
                    end else begin
                        state_nxt_s = OCIOSO;
                    end
                end
                EXIBE: begin
                    // Early drop and final frame end collapse into one fim_msg pulse.
                    if (!bus.erros[sel_r] || (frame_end_s && (frame_r == FRAME_LAST))) begin
                        state_nxt_s = PAUSA;
                        fim_nxt_s   = 1'b1;
                        presc_nxt_s = {PRESC_W{1'b0}};
                        scan_nxt_s  = 2'd0;
                        frame_nxt_s = {FRAME_W{1'b0}};
                    end else if (frame_end_s) begin
                        frame_nxt_s = frame_r + FRAME_W'(1);
                    end else begin
                        frame_nxt_s = frame_r;
                    end
                end
                PAUSA: begin
                    if (frame_end_s) begin
                        presc_nxt_s = {PRESC_W{1'b0}};
                        scan_nxt_s  = 2'd0;
                        frame_nxt_s = {FRAME_W{1'b0}};
                        if (bus.erros == 4'b0000) begin
                            state_nxt_s = OCIOSO;
                        end else begin
                            state_nxt_s = EXIBE;
                            sel_nxt_s   = next_set(bus.erros, sel_r);
                        end
                    end else begin
                        state_nxt_s = PAUSA;
                    end
                end
                default: begin
                    state_nxt_s = OCIOSO;
                    presc_nxt_s = {PRESC_W{1'b0}};
                    scan_nxt_s  = 2'd0;
                    frame_nxt_s = {FRAME_W{1'b0}};
                end
            endcase
        end
    end

    // State, counters and outputs register together so outputs match the new state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= OCIOSO;
            presc_r    <= {PRESC_W{1'b0}};
            scan_r     <= 2'd0;
            frame_r    <= {FRAME_W{1'b0}};
            sel_r      <= 2'd0;
            digito_r   <= 4'b1111;
            exibindo_r <= 1'b0;
            fim_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            presc_r    <= presc_nxt_s;
            scan_r     <= scan_nxt_s;
            frame_r    <= frame_nxt_s;
            sel_r      <= sel_nxt_s;
            digito_r   <= (state_nxt_s == EXIBE) ? digit_mask(scan_nxt_s) : 4'b1111;
            exibindo_r <= (state_nxt_s == EXIBE);
            fim_r      <= fim_nxt_s;
        end
    end

    assign bus.sel_msg        = sel_r;
    assign bus.saida1Contador = scan_r[1];
    assign bus.saida2Contador = scan_r[0];
    assign bus.digito         = digito_r;
    assign bus.exibindo       = exibindo_r;
    assign bus.fim_msg        = fim_r;
endmodule

// File: tb/tb_escalonador_display.sv
// Directed bench for escalonador_display with DIV_VARREDURA=4, TEMPO_MSG=2
// (frame 16 cycles, message 32 cycles, gap 16 cycles).
module tb_escalonador_display;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    escalonador_display_if bus ();

    escalonador_display #(.DIV_VARREDURA(4), .TEMPO_MSG(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst;
        logic       hab;
        logic [3:0] err;
        int         cyc;
        logic [1:0] sel;
        logic [1:0] pair;
        logic [3:0] dig;
        logic       exib;
        logic       fim;
    } vec_t;

    vec_t tbl[$];

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input string field, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %b, expected %b at %0t", name, field, got, exp, $time);
        end
    endtask

    task automatic check_out(input string name, input logic [1:0] sel, input logic [1:0] pair,
                             input logic [3:0] dig, input logic exib, input logic fim);
        chk(name, "sel_msg",  {2'b00, bus.sel_msg}, {2'b00, sel});
        chk(name, "pair",     {2'b00, bus.saida1Contador, bus.saida2Contador}, {2'b00, pair});
        chk(name, "digito",   bus.digito, dig);
        chk(name, "exibindo", {3'b000, bus.exibindo}, {3'b000, exib});
        chk(name, "fim_msg",  {3'b000, bus.fim_msg}, {3'b000, fim});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.habilita = 1'b0;
        bus.erros    = 4'b0000;

        // Single error timeline, then round-robin over 4'b1011.
        tbl.push_back('{"reset",      1'b1, 1'b0, 4'b0000,  2, 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0});
        tbl.push_back('{"single_c0",  1'b0, 1'b1, 4'b0100,  1, 2'd2, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"single_c4",  1'b0, 1'b1, 4'b0100,  4, 2'd2, 2'b01, 4'b1101, 1'b1, 1'b0});
        tbl.push_back('{"single_c8",  1'b0, 1'b1, 4'b0100,  4, 2'd2, 2'b10, 4'b1011, 1'b1, 1'b0});
        tbl.push_back('{"single_c12", 1'b0, 1'b1, 4'b0100,  4, 2'd2, 2'b11, 4'b0111, 1'b1, 1'b0});
        tbl.push_back('{"single_c16", 1'b0, 1'b1, 4'b0100,  4, 2'd2, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"single_c31", 1'b0, 1'b1, 4'b0100, 15, 2'd2, 2'b11, 4'b0111, 1'b1, 1'b0});
        tbl.push_back('{"single_fim", 1'b0, 1'b1, 4'b0100,  1, 2'd2, 2'b00, 4'b1111, 1'b0, 1'b1});
        tbl.push_back('{"single_p1",  1'b0, 1'b1, 4'b0100,  1, 2'd2, 2'b00, 4'b1111, 1'b0, 1'b0});
        tbl.push_back('{"single_p15", 1'b0, 1'b1, 4'b0100, 14, 2'd2, 2'b11, 4'b1111, 1'b0, 1'b0});
        tbl.push_back('{"single_re",  1'b0, 1'b1, 4'b0100,  1, 2'd2, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"rr_reset",   1'b1, 1'b1, 4'b1011,  1, 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0});
        tbl.push_back('{"rr_m0",      1'b0, 1'b1, 4'b1011,  1, 2'd0, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"rr_fim0",    1'b0, 1'b1, 4'b1011, 32, 2'd0, 2'b00, 4'b1111, 1'b0, 1'b1});
        tbl.push_back('{"rr_m1",      1'b0, 1'b1, 4'b1011, 16, 2'd1, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"rr_gap1",    1'b0, 1'b1, 4'b1011, 40, 2'd1, 2'b10, 4'b1111, 1'b0, 1'b0});
        tbl.push_back('{"rr_m3",      1'b0, 1'b1, 4'b1011,  8, 2'd3, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"rr_m0b",     1'b0, 1'b1, 4'b1011, 48, 2'd0, 2'b00, 4'b1110, 1'b1, 1'b0});
        tbl.push_back('{"rr_m1b",     1'b0, 1'b1, 4'b1011, 48, 2'd1, 2'b00, 4'b1110, 1'b1, 1'b0});

        foreach (tbl[i]) begin
            reset        = tbl[i].rst;
            bus.habilita = tbl[i].hab;
            bus.erros    = tbl[i].err;
            step(tbl[i].cyc);
            check_out(tbl[i].name, tbl[i].sel, tbl[i].pair, tbl[i].dig, tbl[i].exib, tbl[i].fim);
        end

        // Early drop of message 0 after 7 shown cycles.
        do_reset();
        bus.habilita = 1'b1;
        bus.erros    = 4'b0011;
        step(7);
        check_out("drop_shown", 2'd0, 2'b01, 4'b1101, 1'b1, 1'b0);
        bus.erros = 4'b0010;
        step(1);
        check_out("drop_fim", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b1);
        step(1);
        check_out("drop_single", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0);
        step(15);
        check_out("drop_next", 2'd1, 2'b00, 4'b1110, 1'b1, 1'b0);

        // Drop coincident with the final frame tick, then idle because erros=0.
        do_reset();
        bus.erros = 4'b0001;
        step(32);
        check_out("coinc_c31", 2'd0, 2'b11, 4'b0111, 1'b1, 1'b0);
        bus.erros = 4'b0000;
        step(1);
        check_out("coinc_fim", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b1);
        step(1);
        check_out("coinc_one", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0);
        step(15);
        check_out("coinc_idle", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0);

        // No preemption: bit 0 raised while message 2 is shown.
        do_reset();
        bus.erros = 4'b0100;
        step(6);
        bus.erros = 4'b0101;
        step(26);
        check_out("nopre_c31", 2'd2, 2'b11, 4'b0111, 1'b1, 1'b0);
        step(1);
        check_out("nopre_fim", 2'd2, 2'b00, 4'b1111, 1'b0, 1'b1);
        step(16);
        check_out("nopre_next", 2'd0, 2'b00, 4'b1110, 1'b1, 1'b0);

        // Disable mid-EXIBE, re-enable restarts at the lowest set bit.
        do_reset();
        bus.erros = 4'b1010;
        step(10);
        check_out("dis_shown", 2'd1, 2'b10, 4'b1011, 1'b1, 1'b0);
        bus.habilita = 1'b0;
        step(1);
        check_out("dis_off", 2'd1, 2'b00, 4'b1111, 1'b0, 1'b0);
        bus.erros = 4'b1100;
        step(5);
        check_out("dis_hold", 2'd1, 2'b00, 4'b1111, 1'b0, 1'b0);
        bus.habilita = 1'b1;
        step(1);
        check_out("dis_reen", 2'd2, 2'b00, 4'b1110, 1'b1, 1'b0);

        // Reset in the middle of the blank gap.
        step(32);
        check_out("rst_pausa", 2'd2, 2'b00, 4'b1111, 1'b0, 1'b1);
        step(9);
        check_out("rst_gap9", 2'd2, 2'b10, 4'b1111, 1'b0, 1'b0);
        reset = 1'b1;
        step(1);
        check_out("rst_mid", 2'd0, 2'b00, 4'b1111, 1'b0, 1'b0);
        reset = 1'b0;
        step(1);
        check_out("rst_after", 2'd2, 2'b00, 4'b1110, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
